// File: rtl/gps_fe_monitor_pkg.sv
// Shared constants and helpers for the GPS front-end monitor.
// GPS_FE_HIST_EN widens the snapshot with a four-bin {sign,mag} histogram.
package gps_fe_monitor_pkg;

  localparam int GPS_FE_WIN_LEN   = 16368;
  localparam int GPS_FE_STUCK_LEN = 4096;

  typedef logic [1:0] fe_code_t;

  function automatic int cnt_width(input int win_len);
    return $clog2(win_len + 1);
  endfunction

  function automatic int snap_width(input int cnt_w);
`ifdef GPS_FE_HIST_EN
    return 3 + 6 * cnt_w;
`else
    return 3 + 2 * cnt_w;
`endif
  endfunction

  // Host software builds against this same layout width.
  localparam int GPS_FE_SNAP_W = snap_width(cnt_width(GPS_FE_WIN_LEN));

endpackage

// File: rtl/gps_fe_monitor_if.sv
// Host-side control and status bundle of the front-end monitor.
interface gps_fe_monitor_if;
  logic run;
  logic ser_load;
  logic ser_next;
  logic ser;
  logic win_done;
  logic stuck;

  modport master (output run, ser_load, ser_next, input ser, win_done, stuck);
  modport slave  (input run, ser_load, ser_next, output ser, win_done, stuck);
endinterface

// File: rtl/gps_fe_sync.sv
// Two-flop synchroniser for asynchronous front-end bits.
module gps_fe_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;
endmodule

// File: rtl/gps_fe_monitor.sv
// Re-times the raw sign/mag stream and gathers per-window statistics for serial readout.
// Define GPS_FE_HIST_EN to add the per-code histogram to the snapshot.
module gps_fe_monitor
  import gps_fe_monitor_pkg::*;
#(
  parameter int WIN_LEN   = GPS_FE_WIN_LEN,
  parameter int STUCK_LEN = GPS_FE_STUCK_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               I_sign_raw,
  input  logic               I_mag_raw,
  gps_fe_monitor_if.slave    bus,
  output logic               sample,
  output logic               mag
);
  localparam int CNT_W  = cnt_width(WIN_LEN);
  localparam int SNAP_W = snap_width(CNT_W);
  localparam int SC_W   = $clog2(STUCK_LEN + 1);

  fe_code_t           w_code;
  logic               w_sign;
  logic               w_mag;
  logic               r_sample;
  logic               r_mag;
  logic [CNT_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_sign_cnt;
  logic [CNT_W-1:0]   r_mag_cnt;
  logic [CNT_W-1:0]   r_res_sign;
  logic [CNT_W-1:0]   r_res_mag;
  logic [CNT_W-1:0]   w_sign_sum;
  logic [CNT_W-1:0]   w_mag_sum;
  logic               w_win_last;
  logic               r_unread;
  logic               r_ovf;
  logic [SC_W-1:0]    r_scnt;
  logic               w_stuck;
  logic               r_stuck_seen;
  logic [SNAP_W-1:0]  w_snap_load;
  logic [SNAP_W-1:0]  r_snap;

  gps_fe_sync #(.W(2)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d ({I_sign_raw, I_mag_raw}),
    .o_q (w_code)
  );

  assign w_sign = w_code[1];
  assign w_mag  = w_code[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample <= 1'b0;
      r_mag    <= 1'b0;
    end else begin
      r_sample <= w_sign;
      r_mag    <= w_mag;
    end
  end

  assign sample = r_sample;
  assign mag    = r_mag;

  assign w_win_last   = bus.run && (r_idx == CNT_W'(WIN_LEN - 1));
  assign bus.win_done = w_win_last;
  assign w_sign_sum   = r_sign_cnt + CNT_W'(w_sign);
  assign w_mag_sum    = r_mag_cnt + CNT_W'(w_mag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_sign_cnt <= '0;
      r_mag_cnt  <= '0;
      r_res_sign <= '0;
      r_res_mag  <= '0;
    end else if (!bus.run) begin
      r_idx      <= '0;
      r_sign_cnt <= '0;
      r_mag_cnt  <= '0;
    end else if (w_win_last) begin
      r_res_sign <= w_sign_sum;
      r_res_mag  <= w_mag_sum;
      r_idx      <= '0;
      r_sign_cnt <= '0;
      r_mag_cnt  <= '0;
    end else begin
      r_idx      <= r_idx + CNT_W'(1);
      r_sign_cnt <= w_sign_sum;
      r_mag_cnt  <= w_mag_sum;
    end
  end

  // A window ending in the same cycle as a load re-arms unread and never counts as overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_unread <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_unread <= w_win_last ? 1'b1 : (bus.ser_load ? 1'b0 : r_unread);
      r_ovf    <= bus.ser_load ? 1'b0 : ((w_win_last && r_unread) ? 1'b1 : r_ovf);
    end
  end

  // r_sample holds the previous synchronised sign, so a mismatch is a transition.
  assign w_stuck   = (r_scnt == SC_W'(STUCK_LEN));
  assign bus.stuck = w_stuck;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scnt       <= '0;
      r_stuck_seen <= 1'b0;
    end else begin
      if (w_sign != r_sample) begin
        r_scnt <= '0;
      end else if (!w_stuck) begin
        r_scnt <= r_scnt + SC_W'(1);
      end
      r_stuck_seen <= w_stuck ? 1'b1 : (bus.ser_load ? 1'b0 : r_stuck_seen);
    end
  end

`ifdef GPS_FE_HIST_EN
  logic [3:0][CNT_W-1:0] w_hist_res;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gen_hist
      logic             w_hit;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_res;

      assign w_hit = (w_code == fe_code_t'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
          r_res <= '0;
        end else if (!bus.run) begin
          r_cnt <= '0;
        end else if (w_win_last) begin
          r_res <= r_cnt + CNT_W'(w_hit);
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(w_hit);
        end
      end

      assign w_hist_res[gi] = r_res;
    end
  endgenerate

  assign w_snap_load = {r_unread, r_ovf, r_stuck_seen, r_res_sign, r_res_mag,
                        w_hist_res[0], w_hist_res[1], w_hist_res[2], w_hist_res[3]};
`else
  assign w_snap_load = {r_unread, r_ovf, r_stuck_seen, r_res_sign, r_res_mag};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap <= '0;
    end else if (bus.ser_load) begin
      r_snap <= w_snap_load;
    end else if (bus.ser_next) begin
      r_snap <= {r_snap[SNAP_W-2:0], 1'b0};
    end
  end

  assign bus.ser = r_snap[SNAP_W-1];
endmodule
